// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one shared 4-byte column datapath, one column per clock.
// Accepts a 128-bit state on in_valid/in_ready and returns it on out_valid/out_ready.
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        col_cnt_q, col_cnt_d;
  logic [STATE_W-1:0]      src_q, src_d;
  logic [STATE_W-1:0]      res_q, res_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic [ROWS-1:0][BYTE_W-1:0] col_a, col_b;
  logic [ROWS-1:0][BYTE_W-1:0] a_x2, a_x4, a_x8;
  logic [ROWS-1:0][BYTE_W-1:0] m_09, m_0b, m_0d, m_0e;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? 8'h1B : 8'h00);
  endfunction

  // Byte s[r][c] lives at bit offset 8*(4r+c); column col_cnt_q is the active one.
  always_comb begin : col_select
    col_a = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      col_a[r] = src_q[BYTE_W*(ROWS*r + 32'(col_cnt_q)) +: BYTE_W];
    end
  end

  always_comb begin : col_math
    a_x2 = '0;
    a_x4 = '0;
    a_x8 = '0;
    m_09 = '0;
    m_0b = '0;
    m_0d = '0;
    m_0e = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      a_x2[r] = xtime(col_a[r]);
      a_x4[r] = xtime(a_x2[r]);
      a_x8[r] = xtime(a_x4[r]);
      m_09[r] = a_x8[r] ^ col_a[r];
      m_0b[r] = a_x8[r] ^ a_x2[r] ^ col_a[r];
      m_0d[r] = a_x8[r] ^ a_x4[r] ^ col_a[r];
      m_0e[r] = a_x8[r] ^ a_x4[r] ^ a_x2[r];
    end
    col_b[0] = m_0e[0] ^ m_0b[1] ^ m_0d[2] ^ m_09[3];
    col_b[1] = m_09[0] ^ m_0e[1] ^ m_0b[2] ^ m_0d[3];
    col_b[2] = m_0d[0] ^ m_09[1] ^ m_0e[2] ^ m_0b[3];
    col_b[3] = m_0b[0] ^ m_0d[1] ^ m_09[2] ^ m_0e[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (col_cnt_q == CNT_W'(3)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    col_cnt_d   = col_cnt_q;
    src_d       = src_q;
    res_d       = res_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d     = in_state;
          col_cnt_d = '0;
        end
      end
      BUSY: begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          res_d[BYTE_W*(ROWS*r + 32'(col_cnt_q)) +: BYTE_W] = col_b[r];
        end
        col_cnt_d = col_cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Output flags are pre-decoded from the next state so they leave a flop directly.
  always_ff @(posedge clk or negedge rst_n) begin : data_reg
    if (!rst_n) begin
      col_cnt_q   <= '0;
      src_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      src_q       <= src_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = res_q;

endmodule
